// File: rtl/lab4_tt_engine.sv
// Table-driven N-input Boolean function block with a registered evaluation path
// and a start/done scan that counts the true minterms and finds the lowest one.
module lab4_tt_engine #(
    parameter int N = 4,
    parameter logic [(1<<N)-1:0] TT_INIT = 16'hCDFA
) (
    input  logic                CL2947MP_clk,
    input  logic                CL2947MP_rst,
    input  logic                CL2947MP_tt_load,
    input  logic [(1<<N)-1:0]   CL2947MP_tt_data,
    input  logic                CL2947MP_in_valid,
    input  logic [N-1:0]        CL2947MP_in_vec,
    output logic                CL2947MP_out_valid,
    output logic                CL2947MP_out_f,
    input  logic                CL2947MP_scan_start,
    output logic                CL2947MP_busy,
    output logic                CL2947MP_done,
    output logic [N:0]          CL2947MP_ones,
    output logic [N-1:0]        CL2947MP_first,
    output logic                CL2947MP_none
);

    localparam int SIZE = 1 << N;
    localparam logic [N-1:0] LAST_IDX = {N{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [SIZE-1:0]   tt_q;
    logic [N-1:0]      idx;
    logic              found;
    logic              hit;

    assign hit           = tt_q[idx];
    assign CL2947MP_busy = (state_q == SCAN);
    assign CL2947MP_done = (state_q == DONE);

    always_ff @(posedge CL2947MP_clk) begin
        if (CL2947MP_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (CL2947MP_scan_start) state_d = SCAN;
            SCAN:    if (idx == LAST_IDX) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Table register and eval path; an eval in the load cycle still sees the old table.
    always_ff @(posedge CL2947MP_clk) begin
        if (CL2947MP_rst) begin
            tt_q               <= TT_INIT;
            CL2947MP_out_valid <= 1'b0;
            CL2947MP_out_f     <= 1'b0;
        end else begin
            if (CL2947MP_tt_load && state_q != SCAN) begin
                tt_q <= CL2947MP_tt_data;
            end
            CL2947MP_out_valid <= CL2947MP_in_valid;
            if (CL2947MP_in_valid) begin
                CL2947MP_out_f <= tt_q[CL2947MP_in_vec];
            end
        end
    end

    // Scan datapath; none is resolved on the last index so it is valid during DONE.
    always_ff @(posedge CL2947MP_clk) begin
        if (CL2947MP_rst) begin
            idx            <= '0;
            found          <= 1'b0;
            CL2947MP_ones  <= '0;
            CL2947MP_first <= '0;
            CL2947MP_none  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (CL2947MP_scan_start) begin
                        idx            <= '0;
                        found          <= 1'b0;
                        CL2947MP_ones  <= '0;
                        CL2947MP_first <= '0;
                        CL2947MP_none  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        CL2947MP_ones <= CL2947MP_ones + (N+1)'(1);
                        if (!found) begin
                            CL2947MP_first <= idx;
                            found          <= 1'b1;
                        end
                    end
                    if (idx == LAST_IDX) begin
                        CL2947MP_none <= ~(found | hit);
                    end else begin
                        idx <= idx + N'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab4_tt_engine.sv
// Directed self-checking bench for lab4_tt_engine (N=4, TT_INIT=16'hCDFA).
module tb_lab4_tt_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        tt_load;
    logic [15:0] tt_data;
    logic        in_valid;
    logic [3:0]  in_vec;
    logic        out_valid;
    logic        out_f;
    logic        scan_start;
    logic        busy;
    logic        done;
    logic [4:0]  ones;
    logic [3:0]  first;
    logic        none;

    int checks   = 0;
    int failures = 0;

    lab4_tt_engine #(.N(4), .TT_INIT(16'hCDFA)) dut (
        .CL2947MP_clk        (clk),
        .CL2947MP_rst        (rst),
        .CL2947MP_tt_load    (tt_load),
        .CL2947MP_tt_data    (tt_data),
        .CL2947MP_in_valid   (in_valid),
        .CL2947MP_in_vec     (in_vec),
        .CL2947MP_out_valid  (out_valid),
        .CL2947MP_out_f      (out_f),
        .CL2947MP_scan_start (scan_start),
        .CL2947MP_busy       (busy),
        .CL2947MP_done       (done),
        .CL2947MP_ones       (ones),
        .CL2947MP_first      (first),
        .CL2947MP_none       (none)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] d);
        tt_load = 1'b1;
        tt_data = d;
        tick();
        tt_load = 1'b0;
    endtask

    // Pulses scan_start (optionally with a load) and watches 24 cycles after the start edge.
    task automatic do_scan(input logic ld, input logic [15:0] d,
                           output int busy_cnt, output int busy_in_win,
                           output int done_at, output int done_cnt,
                           output logic [4:0] r_ones, output logic [3:0] r_first,
                           output logic r_none);
        busy_cnt = 0; busy_in_win = 0; done_at = -1; done_cnt = 0;
        r_ones = 'x; r_first = 'x; r_none = 1'bx;
        scan_start = 1'b1;
        tt_load    = ld;
        tt_data    = d;
        tick();
        scan_start = 1'b0;
        tt_load    = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (busy) begin
                busy_cnt++;
                if (c >= 1 && c <= 16) busy_in_win++;
            end
            if (done) begin
                done_cnt++;
                done_at = c;
                r_ones  = ones;
                r_first = first;
                r_none  = none;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({out_valid, out_f, busy, done, ones, first, none} !== 15'd0) begin
            failures++;
            $display("[TB] FAIL reset_outputs got=%b want=0", {out_valid, out_f, busy, done, ones, first, none});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] tt_exp;
        logic [3:0]  spot [3];
        logic        spot_f [3];
        tt_exp = 16'hCDFA;
        do_reset();
        for (int v = 0; v < 16; v++) begin
            in_valid = 1'b1;
            in_vec   = 4'(v);
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_f !== tt_exp[v]) begin
                failures++;
                $display("[TB] FAIL eval_stream vec=%0d got v=%b f=%b want v=1 f=%b", v, out_valid, out_f, tt_exp[v]);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL eval_hold got v=%b f=%b want v=0 f=1", out_valid, out_f);
        end
        spot[0] = 4'b1001; spot_f[0] = 1'b0;
        spot[1] = 4'b1000; spot_f[1] = 1'b1;
        spot[2] = 4'b1111; spot_f[2] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_vec   = spot[i];
            tick();
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || out_f !== spot_f[i]) begin
                failures++;
                $display("[TB] FAIL eval_spot vec=%b got f=%b want f=%b", spot[i], out_f, spot_f[i]);
            end
        end
        tick();
    endtask

    task automatic test_scan_default();
        int bc, bw, da, dc;
        logic [4:0] o; logic [3:0] f; logic n;
        do_reset();
        do_scan(1'b0, 16'h0000, bc, bw, da, dc, o, f, n);
        checks++;
        if (bc !== 16 || bw !== 16) begin
            failures++;
            $display("[TB] FAIL scan_busy got total=%0d in_window=%0d want 16/16", bc, bw);
        end
        checks++;
        if (dc !== 1 || da !== 17) begin
            failures++;
            $display("[TB] FAIL scan_done_timing got count=%0d at=%0d want 1 at 17", dc, da);
        end
        checks++;
        if (o !== 5'd11 || f !== 4'd1 || n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL scan_cdfa got ones=%0d first=%0d none=%b want 11 1 0", o, f, n);
        end
        checks++;
        if (ones !== 5'd11 || first !== 4'd1 || none !== 1'b0) begin
            failures++;
            $display("[TB] FAIL scan_result_hold got ones=%0d first=%0d none=%b want 11 1 0", ones, first, none);
        end
    endtask

    task automatic test_scan_loads();
        logic [15:0] tabs [3];
        logic [4:0]  e_o  [3];
        logic [3:0]  e_f  [3];
        logic        e_n  [3];
        int bc, bw, da, dc;
        logic [4:0] o; logic [3:0] f; logic n;
        tabs[0] = 16'h0000; e_o[0] = 5'd0;  e_f[0] = 4'd0;  e_n[0] = 1'b1;
        tabs[1] = 16'hFFFF; e_o[1] = 5'd16; e_f[1] = 4'd0;  e_n[1] = 1'b0;
        tabs[2] = 16'h8000; e_o[2] = 5'd1;  e_f[2] = 4'd15; e_n[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_load(tabs[i]);
            do_scan(1'b0, 16'h0000, bc, bw, da, dc, o, f, n);
            checks++;
            if (dc !== 1 || o !== e_o[i] || f !== e_f[i] || n !== e_n[i]) begin
                failures++;
                $display("[TB] FAIL scan_load tt=%h got done=%0d ones=%0d first=%0d none=%b want 1 %0d %0d %b",
                         tabs[i], dc, o, f, n, e_o[i], e_f[i], e_n[i]);
            end
        end
    endtask

    task automatic test_load_with_scan_start();
        int bc, bw, da, dc;
        logic [4:0] o; logic [3:0] f; logic n;
        do_reset();
        do_scan(1'b1, 16'h0010, bc, bw, da, dc, o, f, n);
        checks++;
        if (dc !== 1 || o !== 5'd1 || f !== 4'd4 || n !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_with_start got done=%0d ones=%0d first=%0d none=%b want 1 1 4 0", dc, o, f, n);
        end
    endtask

    task automatic test_load_vs_eval();
        do_reset();
        tt_load  = 1'b1;
        tt_data  = 16'h0001;
        in_valid = 1'b1;
        in_vec   = 4'd0;
        tick();
        tt_load  = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b0) begin
            failures++;
            $display("[TB] FAIL load_eval_old got v=%b f=%b want v=1 f=0", out_valid, out_f);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL load_eval_new got v=%b f=%b want v=1 f=1", out_valid, out_f);
        end
        tick();
    endtask

    task automatic test_scan_ignores();
        int dc;
        logic [4:0] o;
        do_reset();
        dc = 0;
        o  = 'x;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            if (done) begin
                dc++;
                o = ones;
            end
            tt_load    = (c == 5);
            tt_data    = 16'h0000;
            scan_start = (c == 9);
            tick();
        end
        tt_load    = 1'b0;
        scan_start = 1'b0;
        checks++;
        if (dc !== 1 || o !== 5'd11) begin
            failures++;
            $display("[TB] FAIL scan_ignores got done=%0d ones=%0d want 1 11", dc, o);
        end
        in_valid = 1'b1;
        in_vec   = 4'd1;
        tick();
        in_vec   = 4'd3;
        checks++;
        if (out_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scan_table_kept vec=1 got f=%b want 1", out_f);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_f !== 1'b1) begin
            failures++;
            $display("[TB] FAIL scan_table_kept vec=3 got f=%b want 1", out_f);
        end
        tick();
    endtask

    task automatic test_reset_mid_scan();
        int dc, bc, bw, da;
        logic [4:0] o; logic [3:0] f; logic n;
        do_reset();
        do_load(16'hFFFF);
        dc = 0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        for (int c = 1; c < 8; c++) begin
            if (done) dc++;
            tick();
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || ones !== 5'd0 || done !== 1'b0 || first !== 4'd0 || none !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_mid_scan got busy=%b ones=%0d done=%b first=%0d none=%b want 0 0 0 0 0",
                     busy, ones, done, first, none);
        end
        rst = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done) dc++;
            tick();
        end
        checks++;
        if (dc !== 0) begin
            failures++;
            $display("[TB] FAIL reset_no_done got done_count=%0d want 0", dc);
        end
        do_scan(1'b0, 16'h0000, bc, bw, da, dc, o, f, n);
        checks++;
        if (dc !== 1 || o !== 5'd11 || f !== 4'd1) begin
            failures++;
            $display("[TB] FAIL rescan_after_reset got done=%0d ones=%0d first=%0d want 1 11 1", dc, o, f);
        end
    endtask

    initial begin
        rst        = 1'b1;
        tt_load    = 1'b0;
        tt_data    = 16'h0000;
        in_valid   = 1'b0;
        in_vec     = 4'd0;
        scan_start = 1'b0;
        tick();
        test_reset();
        test_back_to_back();
        test_scan_default();
        test_scan_loads();
        test_load_with_scan_start();
        test_load_vs_eval();
        test_scan_ignores();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
